// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential ALU: default datapath
//                width, opcode encodings, FSM state type and an opcode
//                classification helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH_DEFAULT = 18;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // Opcodes PASS..SHR complete in a single clock.
    function automatic logic is_single_cycle_op(input logic [3:0] op);
        return (op <= OP_SHR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul_shift_add.sv
`default_nettype none
// ============================================================================
//  Module      : mul_shift_add
//  Description : Iterative unsigned shift-add multiplier. The first partial
//                product is formed on the start edge, the remaining WIDTH-1
//                on the following edges; done pulses for one cycle with the
//                full 2*WIDTH product valid on product.
//  Ports       : clk, rst (async, active-low), start, a, b -> done, product
//  Revision    : 1.0  initial release
// ============================================================================
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               active_q, active_d;
    logic               done_q,  done_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (start) begin
            // Iteration 0 happens here so the product is ready exactly
            // WIDTH-1 edges later, letting the caller write on edge N+WIDTH.
            mcand_d  = {{WIDTH{1'b0}}, a} << 1;
            mplier_d = b >> 1;
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            cnt_d    = CNT_W'(WIDTH - 1);
            active_d = (WIDTH > 1);
            done_d   = (WIDTH == 1);
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU feeding the accumulator. Single-cycle ops
//                write result/flags and pulse wr_ac one cycle after accept;
//                MUL runs on the iterative multiplier with busy asserted.
//  Ports       : clk, rst (async, active-low), start, op[3:0], a, b
//                -> result, wr_ac, busy, flag_z, flag_n, flag_c, err
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             wr_ac,
    output logic             busy,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, z_d;
    logic               n_q, n_d;
    logic               c_q, c_d;
    logic               wr_ac_q, wr_ac_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;

    mul_shift_add #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath; the extra top bit of sub_w is the borrow.
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_PASS: alu_res = b;
            OP_ADD:  {alu_c, alu_res} = add_w;
            OP_SUB:  {alu_c, alu_res} = sub_w;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            OP_SHL:  begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            OP_SHR:  begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        wr_ac_d   = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = MUL;
                    end else if (is_single_cycle_op(op)) begin
                        result_d = alu_res;
                        c_d      = alu_c;
                        z_d      = (alu_res == '0);
                        n_d      = alu_res[WIDTH-1];
                        wr_ac_d  = 1'b1;
                    end else begin
                        // Illegal opcode: only err moves, visible state holds.
                        err_d = 1'b1;
                    end
                end
            end
            MUL: begin
                // start is not looked at here, so requests while busy drop.
                if (mul_done) begin
                    result_d = mul_product[WIDTH-1:0];
                    c_d      = |mul_product[2*WIDTH-1:WIDTH];
                    z_d      = (mul_product[WIDTH-1:0] == '0);
                    n_d      = mul_product[WIDTH-1];
                    wr_ac_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            wr_ac_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            wr_ac_q  <= wr_ac_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign wr_ac  = wr_ac_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire
